cpu_run_ctrl: RTL and testbench

Synthesizable run controller that sequences the CPU through reset hold, run, pause and completion. It replaces the hand-coded reset/start/sw_int stimulus with a parametrised block. It generalises the single pause switch to NUM_SRC maskable pause sources and adds a cycle budget plus run/pause cycle counters. It sits between board inputs (switches, buttons) and the CPU top: it drives the CPU reset and clock-enable, and exposes its counters for the seven-segment/debug path.

---
 rtl/cpu_run_pkg.sv | 15 +
 rtl/cpu_run_ctrl_sat_counter.sv | 26 ++
 rtl/cpu_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared state encoding and default widths for the CPU run controller.
package cpu_run_pkg;

    localparam int STATE_W   = 3;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset hold, run, maskable pause, cycle budget and counters.
// Optional single-step gating of RUN is enabled by defining CPU_RUN_CTRL_STEP_EN.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RESET_CYCLES = 5
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_SRC-1:0] pause_req,
    input  logic [NUM_SRC-1:0] pause_mask,
    input  logic [CNT_W-1:0]   run_budget,
`ifdef CPU_RUN_CTRL_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic               cpu_reset,
    output logic               cpu_en,
    output logic [STATE_W-1:0] state_o,
    output logic [NUM_SRC-1:0] pause_src,
    output logic [CNT_W-1:0]   run_cnt,
    output logic [CNT_W-1:0]   pause_cnt,
    output logic               done
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  r_hold;
    logic [NUM_SRC-1:0] r_pause_src;
    logic [NUM_SRC-1:0] w_masked;
    logic               w_pause_any;
    logic               w_run_tick;
    logic               w_budget_hit;
    logic               w_accept;
    logic               w_live;
    logic [CNT_W-1:0]   w_run_cnt;
    logic [CNT_W-1:0]   w_pause_cnt;

    assign w_masked    = pause_req & ~pause_mask;
    assign w_pause_any = |w_masked;
    assign w_live      = enable && !abort;
    assign w_accept    = w_live && start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef CPU_RUN_CTRL_STEP_EN
    logic r_step_d;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
        end
    end

    // In step mode the CPU only advances in the cycle following a step pulse.
    assign w_run_tick = enable && (r_state == ST_RUN) && (!step_mode || r_step_d);
`else
    assign w_run_tick = enable && (r_state == ST_RUN);
`endif

    // Budget compares against the pre-increment count so run_cnt lands on run_budget.
    assign w_budget_hit = w_run_tick && (run_budget != '0) &&
                          (w_run_cnt == run_budget - CNT_W'(1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else if (enable) begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_HOLD;
                ST_HOLD:          if (r_hold == '0) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_budget_hit)     w_state_nxt = ST_DONE;
                    else if (w_pause_any) w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE:         if (!w_pause_any) w_state_nxt = ST_RUN;
                default:          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_reset = (r_state == ST_IDLE) || (r_state == ST_HOLD);
        cpu_en    = w_run_tick;
        done      = (r_state == ST_DONE);
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_pause_src <= '0;
        end else if (w_live) begin
            if (w_accept) begin
                r_hold      <= HOLD_W'(RESET_CYCLES - 1);
                r_pause_src <= '0;
            end else if ((r_state == ST_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
            if ((r_state == ST_RUN) && !w_budget_hit && w_pause_any) begin
                r_pause_src <= w_masked;
            end else if (r_state == ST_PAUSE) begin
                r_pause_src <= r_pause_src | w_masked;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .i_clk   (clk_in),
        .i_rst_n (reset),
        .i_clr   (w_accept),
        .i_inc   (w_run_tick && !abort),
        .o_cnt   (w_run_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_pause_cnt (
        .i_clk   (clk_in),
        .i_rst_n (reset),
        .i_clr   (w_accept),
        .i_inc   (w_live && (r_state == ST_PAUSE)),
        .o_cnt   (w_pause_cnt)
    );

    assign state_o   = r_state;
    assign pause_src = r_pause_src;
    assign run_cnt   = w_run_cnt;
    assign pause_cnt = w_pause_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: hold timing, budget, masked pause, enable, abort, reset, saturation.
module tb_cpu_run_ctrl;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  pause_req = 2'b00;
    logic [1:0]  pause_mask = 2'b00;
    logic [31:0] run_budget = 32'd0;
    logic [3:0]  run_budget4 = 4'd0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;

    logic        cpu_reset, cpu_en, done;
    logic [2:0]  state_o;
    logic [1:0]  pause_src;
    logic [31:0] run_cnt, pause_cnt;

    logic        cpu_reset4, cpu_en4, done4;
    logic [2:0]  state4;
    logic [1:0]  pause_src4;
    logic [3:0]  run_cnt4, pause_cnt4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;

    cpu_run_ctrl #(.NUM_SRC(2), .CNT_W(32), .RESET_CYCLES(5)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .start(start), .abort(abort),
        .pause_req(pause_req), .pause_mask(pause_mask), .run_budget(run_budget),
`ifdef CPU_RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .cpu_reset(cpu_reset), .cpu_en(cpu_en), .state_o(state_o), .pause_src(pause_src),
        .run_cnt(run_cnt), .pause_cnt(pause_cnt), .done(done)
    );

    cpu_run_ctrl #(.NUM_SRC(2), .CNT_W(4), .RESET_CYCLES(5)) dut4 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .start(start), .abort(abort),
        .pause_req(pause_req), .pause_mask(pause_mask), .run_budget(run_budget4),
`ifdef CPU_RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .cpu_reset(cpu_reset4), .cpu_en(cpu_en4), .state_o(state4), .pause_src(pause_src4),
        .run_cnt(run_cnt4), .pause_cnt(pause_cnt4), .done(done4)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Abort to IDLE, accept start, then step through the 5 HOLD cycles into RUN.
    task automatic do_start(input logic [31:0] budget);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_budget = budget;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_total++; if (state_o !== 3'd0) $display("FAIL rst_state: got %0d want 0", state_o); else n_pass++;
        n_total++; if ({cpu_reset, cpu_en, done} !== 3'b100) $display("FAIL rst_outs: got %b want 100", {cpu_reset, cpu_en, done}); else n_pass++;
        n_total++; if ({run_cnt, pause_cnt} !== 64'd0) $display("FAIL rst_cnts: got %0d/%0d want 0/0", run_cnt, pause_cnt); else n_pass++;
        n_total++; if (pause_src !== 2'b00) $display("FAIL rst_src: got %b want 00", pause_src); else n_pass++;
        enable = 1'b1;
        start = 1'b1;
        tick();
        n_total++; if (state_o !== 3'd0) $display("FAIL rst_hold_idle: got %0d want 0", state_o); else n_pass++;
        #2 reset = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_start_hold();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (cpu_reset !== 1'b1 || state_o !== 3'd1)
                $display("FAIL hold_cycle%0d: got rst=%b st=%0d want rst=1 st=1", i, cpu_reset, state_o);
            else n_pass++;
            tick();
        end
        n_total++; if (state_o !== 3'd2 || cpu_reset !== 1'b0 || cpu_en !== 1'b1)
            $display("FAIL run_entry: got st=%0d rst=%b en=%b want 2/0/1", state_o, cpu_reset, cpu_en); else n_pass++;
        n_total++; if (run_cnt !== 32'd0) $display("FAIL run_cnt0: got %0d want 0", run_cnt); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++; if (run_cnt !== 32'(i)) $display("FAIL run_cnt_step: got %0d want %0d", run_cnt, i); else n_pass++;
        end
        repeat (20) tick();
        n_total++; if (run_cnt !== 32'd23) $display("FAIL run_cnt23: got %0d want 23", run_cnt); else n_pass++;
        n_total++; if (run_cnt4 !== 4'd15) $display("FAIL sat4: got %0d want 15", run_cnt4); else n_pass++;
    endtask

    task automatic test_budget();
        do_start(32'd100);
        repeat (99) tick();
        n_total++; if (state_o !== 3'd2 || run_cnt !== 32'd99)
            $display("FAIL budget_pre: got st=%0d cnt=%0d want 2/99", state_o, run_cnt); else n_pass++;
        tick();
        n_total++; if (state_o !== 3'd4 || run_cnt !== 32'd100)
            $display("FAIL budget_done: got st=%0d cnt=%0d want 4/100", state_o, run_cnt); else n_pass++;
        n_total++; if (done !== 1'b1 || cpu_en !== 1'b0)
            $display("FAIL budget_outs: got done=%b en=%b want 1/0", done, cpu_en); else n_pass++;
        repeat (3) tick();
        n_total++; if (run_cnt !== 32'd100 || state_o !== 3'd4)
            $display("FAIL done_hold: got st=%0d cnt=%0d want 4/100", state_o, run_cnt); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (state_o !== 3'd1 || run_cnt !== 32'd0 || done !== 1'b0)
            $display("FAIL done_restart: got st=%0d cnt=%0d done=%b want 1/0/0", state_o, run_cnt, done); else n_pass++;
    endtask

    task automatic test_pause_mask();
        do_start(32'd0);
        pause_mask = 2'b10;
        pause_req = 2'b10;
        repeat (20) tick();
        n_total++; if (state_o !== 3'd2 || run_cnt !== 32'd20 || pause_cnt !== 32'd0)
            $display("FAIL masked_nopause: got st=%0d run=%0d pz=%0d want 2/20/0", state_o, run_cnt, pause_cnt); else n_pass++;
        pause_req = 2'b01;
        tick();
        n_total++; if (state_o !== 3'd3 || pause_src !== 2'b01 || run_cnt !== 32'd21)
            $display("FAIL pause_entry: got st=%0d src=%b run=%0d want 3/01/21", state_o, pause_src, run_cnt); else n_pass++;
        repeat (49) tick();
        n_total++; if (state_o !== 3'd3 || pause_cnt !== 32'd49 || run_cnt !== 32'd21 || cpu_en !== 1'b0)
            $display("FAIL pause_mid: got st=%0d pz=%0d run=%0d en=%b want 3/49/21/0", state_o, pause_cnt, run_cnt, cpu_en); else n_pass++;
        pause_req = 2'b00;
        tick();
        n_total++; if (state_o !== 3'd2 || pause_cnt !== 32'd50 || run_cnt !== 32'd21)
            $display("FAIL pause_exit: got st=%0d pz=%0d run=%0d want 2/50/21", state_o, pause_cnt, run_cnt); else n_pass++;
        tick();
        n_total++; if (run_cnt !== 32'd22 || pause_src !== 2'b01)
            $display("FAIL resume_run: got run=%0d src=%b want 22/01", run_cnt, pause_src); else n_pass++;
    endtask

    task automatic test_pause_or_mask();
        do_start(32'd0);
        pause_mask = 2'b00;
        pause_req = 2'b01;
        tick();
        pause_req = 2'b11;
        tick();
        n_total++; if (state_o !== 3'd3 || pause_src !== 2'b11)
            $display("FAIL pause_or: got st=%0d src=%b want 3/11", state_o, pause_src); else n_pass++;
        pause_mask = 2'b11;
        tick();
        n_total++; if (state_o !== 3'd2) $display("FAIL mask_resume: got st=%0d want 2", state_o); else n_pass++;
        pause_req = 2'b00;
        pause_mask = 2'b00;
    endtask

    task automatic test_budget_vs_pause();
        do_start(32'd3);
        repeat (2) tick();
        pause_req = 2'b01;
        tick();
        n_total++; if (state_o !== 3'd4 || run_cnt !== 32'd3 || pause_src !== 2'b00)
            $display("FAIL budget_wins: got st=%0d run=%0d src=%b want 4/3/00", state_o, run_cnt, pause_src); else n_pass++;
        pause_req = 2'b00;
    endtask

    task automatic test_enable_freeze();
        do_start(32'd0);
        repeat (3) tick();
        enable = 1'b0;
        repeat (10) tick();
        n_total++; if (state_o !== 3'd2 || run_cnt !== 32'd3 || cpu_en !== 1'b0)
            $display("FAIL en_freeze: got st=%0d run=%0d en=%b want 2/3/0", state_o, run_cnt, cpu_en); else n_pass++;
        enable = 1'b1;
        tick();
        n_total++; if (run_cnt !== 32'd4 || cpu_en !== 1'b1)
            $display("FAIL en_resume: got run=%0d en=%b want 4/1", run_cnt, cpu_en); else n_pass++;
    endtask

    task automatic test_abort_pause();
        do_start(32'd0);
        pause_req = 2'b01;
        repeat (2) tick();
        n_total++; if (state_o !== 3'd3) $display("FAIL abort_pre: got st=%0d want 3", state_o); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pause_req = 2'b00;
        n_total++; if (state_o !== 3'd0 || cpu_reset !== 1'b1 || cpu_en !== 1'b0)
            $display("FAIL abort_idle: got st=%0d rst=%b en=%b want 0/1/0", state_o, cpu_reset, cpu_en); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_start(32'd0);
        repeat (2) tick();
        #3 reset = 1'b0;
        #1;
        n_total++; if (state_o !== 3'd0 || {cpu_reset, cpu_en, done} !== 3'b100)
            $display("FAIL areset_outs: got st=%0d outs=%b want 0/100", state_o, {cpu_reset, cpu_en, done}); else n_pass++;
        n_total++; if (run_cnt !== 32'd0 || pause_cnt !== 32'd0 || pause_src !== 2'b00)
            $display("FAIL areset_cnts: got run=%0d pz=%0d src=%b want 0/0/00", run_cnt, pause_cnt, pause_src); else n_pass++;
        #2 reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_budget();
        test_pause_mask();
        test_pause_or_mask();
        test_budget_vs_pause();
        test_enable_freeze();
        test_abort_pause();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
